alu_mul_sequencer: RTL

//   Multi-cycle initiator for the datapath ALU: computes the low N bits of the unsigned product a*b by shift-and-add.

---
 rtl/alu_mul_sequencer_if.sv | 38 +++
 rtl/alu_mul_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer_if.sv
// ============================================================================
// Module      : alu_mul_sequencer_if
// Description : Request, response and ALU-side signals of the shift-and-add
//               multiply sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mul_sequencer_if #(
  parameter int N  = 32,
  parameter int CW = 6
);
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req_a;
  logic [N-1:0]  req_b;
  logic [N-1:0]  alu_in1;
  logic [N-1:0]  alu_in2;
  logic [4:0]    alu_func;
  logic [N-1:0]  alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_prod;
  logic [CW-1:0] rsp_steps;

  // Environment side: requester, consumer and the external ALU
  modport master (
    output req_valid, req_a, req_b, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_prod, rsp_steps, alu_in1, alu_in2, alu_func
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_prod, rsp_steps, alu_in1, alu_in2, alu_func
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Shift-and-add multiplier issuing one ADD per cycle to an
//               external ALU. Optional macro EARLY_TERM_EN stops the loop once
//               no multiplier bits remain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_mul_sequencer_if.slave bus
);

  localparam logic [4:0] ALU_ADD = 5'b0_00_10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q,  state_d;
  logic [N-1:0]  acc_q,    acc_d;
  logic [N-1:0]  mcand_q,  mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          last_run;
  logic          start_done;

`ifdef EARLY_TERM_EN
  assign last_run   = ((mplier_q >> 1) == '0);
  assign start_done = (bus.req_b == '0);
`else
  assign last_run   = (cnt_q == CW'(N - 1));
  assign start_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.alu_func  = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          mcand_d  = bus.req_a;
          mplier_d = bus.req_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = start_done ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The ALU adds the current partial product; its result is the new accumulator
        bus.alu_in1 = acc_q;
        bus.alu_in2 = mplier_q[0] ? mcand_q : '0;
        acc_d       = bus.alu_out;
        mcand_d     = mcand_q << 1;
        mplier_d    = mplier_q >> 1;
        cnt_d       = cnt_q + CW'(1);
        if (last_run) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // acc and cnt are frozen in DONE, so the response fields stay stable while stalled
  assign bus.rsp_prod  = acc_q;
  assign bus.rsp_steps = cnt_q;

endmodule

`default_nettype wire
